// File: rtl/datapath_seq.sv
// datapath_seq: multicycle register-file / ALU datapath.
// One op (ALU, load or store) is accepted per op_valid/op_ready handshake and
// walks through IDLE -> EXEC (-> MEMWAIT) before retiring with a done pulse.
// Memory ops use a req/ack handshake with a bounded wait (TIMEOUT cycles).

module datapath_seq #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter int TIMEOUT = 15,
    localparam int SELW   = $clog2(NREGS)
) (
    input  logic                   clock,
    input  logic                   resetn,
    // op issue interface
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [2:0]             alu_op,
    input  logic [SELW-1:0]        a_sel,
    input  logic [SELW-1:0]        b_sel,
    input  logic [WIDTH-1:0]       a_imm,
    input  logic [WIDTH-1:0]       b_imm,
    input  logic                   a_use_imm,
    input  logic                   b_use_imm,
    input  logic [SELW-1:0]        dest_sel,
    input  logic [1:0]             wb_mode,
    input  logic                   pc_inc,
    // memory interface
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic [WIDTH-1:0]       mem_rdata,
    input  logic                   mem_ack,
    // status / observation
    output logic                   done,
    output logic [WIDTH-1:0]       alu_result,
    output logic [NREGS*WIDTH-1:0] registers,
    output logic [NREGS-1:0]       overflow,
    output logic [NREGS-1:0]       errorbit
);

    // ------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_MEMWAIT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_SHL   = 3'd5,
        ALU_SHR   = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_NONE  = 2'b00,
        WB_ALU   = 2'b01,
        WB_LOAD  = 2'b10,
        WB_STORE = 2'b11
    } wb_mode_e;

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q, state_d;

    logic [WIDTH-1:0]      regs_q [NREGS];
    logic [NREGS-1:0]      ovf_q;
    logic [NREGS-1:0]      err_q;

    // op fields captured at accept
    alu_op_e               alu_op_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [SELW-1:0]       dest_q;
    wb_mode_e              wb_q;
    logic                  pc_inc_q;

    logic [WIDTH-1:0]      alu_result_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  done_q;
    logic [TW-1:0]         tmo_cnt_q;

    // ------------------------------------------------------------------
    // Combinational decode signals
    // ------------------------------------------------------------------
    logic                  accept;
    logic                  is_mem_op;
    logic                  exec_retire;
    logic                  mem_done_ack;
    logic                  mem_timeout;
    logic                  retire;

    logic [WIDTH-1:0]      alu_res;
    logic                  alu_ofl;
    logic                  alu_err;
    logic                  shift_oor;

    logic                  rf_we;
    logic [WIDTH-1:0]      rf_wdata;
    logic                  ofl_we;
    logic                  ofl_wdata;
    logic                  err_we;
    logic                  err_wdata;
    logic                  pc_bump;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register; reset drops straight back to IDLE, aborting any op.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update from the same pre-edge values, independent of order.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d; a missing
        // branch would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept)                        state_d = S_EXEC;
            S_EXEC:    state_d = is_mem_op ? S_MEMWAIT : S_IDLE;
            S_MEMWAIT: if (mem_done_ack || mem_timeout)   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / decode logic derived from the current state.
    always_comb begin
        op_ready     = (state_q == S_IDLE);
        accept       = (state_q == S_IDLE) && op_valid;
        is_mem_op    = wb_q[1];
        exec_retire  = (state_q == S_EXEC) && !is_mem_op;
        // an ack in the same cycle as the timeout wins
        mem_done_ack = (state_q == S_MEMWAIT) && mem_ack;
        mem_timeout  = (state_q == S_MEMWAIT) && !mem_ack && (tmo_cnt_q == TMO_LAST);
        retire       = exec_retire || mem_done_ack || mem_timeout;
    end

    // ------------------------------------------------------------------
    // ALU (operates on the operands captured at accept)
    // ------------------------------------------------------------------

    // Combinational ALU with signed-overflow and shift-range flags.
    always_comb begin
        alu_res   = '0;
        alu_ofl   = 1'b0;
        alu_err   = 1'b0;
        shift_oor = (b_q >= WIDTH_V);
        unique case (alu_op_q)
            ALU_ADD: begin
                alu_res = a_q + b_q;
                alu_ofl = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = a_q - b_q;
                alu_ofl = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_AND:   alu_res = a_q & b_q;
            ALU_OR:    alu_res = a_q | b_q;
            ALU_XOR:   alu_res = a_q ^ b_q;
            ALU_SHL: begin
                if (shift_oor) alu_err = 1'b1;
                else           alu_res = a_q << b_q[SHW-1:0];
            end
            ALU_SHR: begin
                if (shift_oor) alu_err = 1'b1;
                else           alu_res = a_q >> b_q[SHW-1:0];
            end
            ALU_PASSB: alu_res = b_q;
            default:   alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register-file write decode
    // ------------------------------------------------------------------

    // Select what (if anything) is written to r[dest] and its flags on retire.
    always_comb begin
        rf_we     = 1'b0;
        rf_wdata  = alu_res;
        ofl_we    = 1'b0;
        ofl_wdata = 1'b0;
        err_we    = 1'b0;
        err_wdata = 1'b0;

        if (exec_retire && (wb_q == WB_ALU)) begin
            rf_we     = 1'b1;
            rf_wdata  = alu_res;
            ofl_we    = 1'b1;
            ofl_wdata = alu_ofl;
            err_we    = 1'b1;
            err_wdata = alu_err;
        end else if (mem_done_ack && (wb_q == WB_LOAD)) begin
            rf_we     = 1'b1;
            rf_wdata  = mem_rdata;
            ofl_we    = 1'b1;
            err_we    = 1'b1;
        end else if (mem_timeout) begin
            // aborted access: flag it, leave the register value alone
            err_we    = 1'b1;
            err_wdata = 1'b1;
        end

        // an explicit write of r0 takes priority over the PC increment
        pc_bump = retire && pc_inc_q && !(rf_we && (dest_q == '0));
    end

    // Register file and per-register flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the register file is architecturally zero after reset,
            // so this array is reset explicitly (it is not a RAM macro).
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            ovf_q <= '0;
            err_q <= '0;
        end else begin
            if (rf_we)   regs_q[dest_q] <= rf_wdata;
            if (pc_bump) regs_q[0]      <= regs_q[0] + WIDTH'(1);
            if (ofl_we)  ovf_q[dest_q]  <= ofl_wdata;
            if (err_we)  err_q[dest_q]  <= err_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Op capture, ALU result, memory handshake and done pulse
    // ------------------------------------------------------------------

    // Capture op fields and operand values at accept (reads see the current file).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            alu_op_q    <= ALU_ADD;
            a_q         <= '0;
            b_q         <= '0;
            dest_q      <= '0;
            wb_q        <= WB_NONE;
            pc_inc_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else if (accept) begin
            alu_op_q    <= alu_op_e'(alu_op);
            a_q         <= a_use_imm ? a_imm : regs_q[a_sel];
            b_q         <= b_use_imm ? b_imm : regs_q[b_sel];
            dest_q      <= dest_sel;
            wb_q        <= wb_mode_e'(wb_mode);
            pc_inc_q    <= pc_inc;
            mem_wdata_q <= regs_q[dest_sel];
        end
    end

    // Result register, memory request/timeout tracking and the done pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            alu_result_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= retire;

            if (state_q == S_EXEC) begin
                alu_result_q <= alu_res;
                tmo_cnt_q    <= '0;
                if (is_mem_op) begin
                    mem_req_q <= 1'b1;
                    mem_we_q  <= wb_q[0];
                end
            end

            if (state_q == S_MEMWAIT) begin
                if (mem_done_ack || mem_timeout) begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = alu_result_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign alu_result = alu_result_q;
    assign overflow   = ovf_q;
    assign errorbit   = err_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign registers[g*WIDTH +: WIDTH] = regs_q[g];
    end

endmodule
